// File: rtl/led_scroller_pkg.sv
// Shared encodings for the LED scroller: motion modes, bounce direction, load FSM.
package led_scroller_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned SUB_W  = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        LD_READY = 1'b0,
        LD_BUSY  = 1'b1
    } load_state_e;

endpackage

// File: rtl/led_scroller_ctrl_tick_prescaler.sv
// Base-tick prescaler: counts 0..CNT_1S-1 while enabled, tick flags the terminal count.
module tick_prescaler #(
    parameter int unsigned      CNT_W  = 27,
    parameter logic [CNT_W-1:0] CNT_1S = CNT_W'(100_000_000)
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_1S - CNT_W'(1));
    assign tick = en && wrap;

    // clr beats en so a pattern load restarts the period even while paused
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_scroller_ctrl.sv
// LED scroller: prescaled step generator, four motion modes, pause and a valid/ready pattern load.
module led_scroller_ctrl #(
    parameter int unsigned      LED_W    = 16,
    parameter int unsigned      CNT_W    = 27,
    parameter logic [CNT_W-1:0] CNT_1S   = CNT_W'(100_000_000),
    parameter logic [LED_W-1:0] INIT_PAT = LED_W'(1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             pat_valid,
    input  logic [LED_W-1:0] pat_data,
    output logic             pat_ready,
    output logic [LED_W-1:0] led,
    output logic             step_pulse
);

    import led_scroller_pkg::*;

    load_state_e      state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [SUB_W-1:0] sub_q, sub_d, sub_limit;
    logic [LED_W-1:0] led_d;
    logic             pat_ready_d, step_pulse_d;
    logic             tick, step, accept;

    tick_prescaler #(
        .CNT_W (CNT_W),
        .CNT_1S(CNT_1S)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .en    (~pause),
        .clr   (accept),
        .tick  (tick)
    );

    assign sub_limit = SUB_W'((1 << speed) - 1);
    assign accept    = (state_q == LD_READY) && pat_valid;
    assign step      = tick && (sub_q == sub_limit);

    // Next-state and next-output logic; an accepted load overrides any due step
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        sub_d        = sub_q;
        led_d        = led;
        pat_ready_d  = 1'b1;
        step_pulse_d = 1'b0;

        case (state_q)
            LD_READY: if (accept) state_d = LD_BUSY;
            LD_BUSY:  state_d = LD_READY;
            default:  state_d = LD_READY;
        endcase

        if (tick) begin
            sub_d = step ? '0 : sub_q + SUB_W'(1);
        end

        if (accept) begin
            led_d = pat_data;
            dir_d = DIR_LEFT;
            sub_d = '0;
        end else if (step) begin
            step_pulse_d = 1'b1;
            case (mode_e'(mode))
                MODE_ROL: led_d = {led[LED_W-2:0], led[LED_W-1]};
                MODE_ROR: led_d = {led[0], led[LED_W-1:1]};
                MODE_BOUNCE: begin
                    if (dir_q == DIR_LEFT && led[LED_W-1]) begin
                        dir_d = DIR_RIGHT;
                        led_d = led >> 1;
                    end else if (dir_q == DIR_RIGHT && led[0]) begin
                        dir_d = DIR_LEFT;
                        led_d = led << 1;
                    end else if (dir_q == DIR_LEFT) begin
                        led_d = led << 1;
                    end else begin
                        led_d = led >> 1;
                    end
                end
                MODE_HOLD: led_d = led;
                default:   led_d = led;
            endcase
        end

        pat_ready_d = (state_d == LD_READY);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LD_READY;
            dir_q      <= DIR_LEFT;
            sub_q      <= '0;
            led        <= INIT_PAT;
            pat_ready  <= 1'b1;
            step_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            sub_q      <= sub_d;
            led        <= led_d;
            pat_ready  <= pat_ready_d;
            step_pulse <= step_pulse_d;
        end
    end

endmodule

// File: tb/tb_led_scroller_ctrl.sv
// Scoreboard bench for led_scroller_ctrl: LED_W=8, CNT_1S=100, directed scenarios then random traffic.
module tb_led_scroller_ctrl;

    localparam int LED_W  = 8;
    localparam int CNT_W  = 27;
    localparam int CNT_1S = 100;
    localparam int HALF   = 5;

    logic             clk       = 1'b0;
    logic             resetn    = 1'b0;
    logic [1:0]       mode      = 2'd0;
    logic [1:0]       speed     = 2'd0;
    logic             pause     = 1'b0;
    logic             pat_valid = 1'b0;
    logic [LED_W-1:0] pat_data  = '0;
    logic             pat_ready;
    logic [LED_W-1:0] led;
    logic             step_pulse;

    led_scroller_ctrl #(
        .LED_W   (LED_W),
        .CNT_W   (CNT_W),
        .CNT_1S  (27'd100),
        .INIT_PAT(8'h01)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mode      (mode),
        .speed     (speed),
        .pause     (pause),
        .pat_valid (pat_valid),
        .pat_data  (pat_data),
        .pat_ready (pat_ready),
        .led       (led),
        .step_pulse(step_pulse)
    );

    always #HALF clk = ~clk;

    typedef struct {
        bit     is_load;
        longint t;
        int     led;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: elapsed unpaused cycles form base ticks, every 2^speed ticks is a step
    int         m_cnt   = 0;
    int         m_sub   = 0;
    int         m_dir   = 0;   // 0 = moving toward MSB, 1 = toward LSB
    int         m_led   = 1;
    bit         m_ready = 1'b1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt = 0; m_sub = 0; m_dir = 0; m_led = 1; m_ready = 1'b1;
        end else if (m_ready && pat_valid) begin
            m_led = int'(pat_data); m_cnt = 0; m_sub = 0; m_dir = 0; m_ready = 1'b0;
            q.push_back('{1'b1, $time, m_led});
        end else begin
            m_ready = 1'b1;
            if (!pause) begin
                if (m_cnt == CNT_1S - 1) begin
                    m_cnt = 0;
                    if (m_sub == (1 << speed) - 1) begin
                        m_sub = 0;
                        case (int'(mode))
                            0: m_led = ((m_led * 2) % 256) + (m_led / 128);
                            1: m_led = (m_led / 2) + ((m_led % 2) * 128);
                            2: begin
                                if (m_dir == 0 && m_led >= 128) m_dir = 1;
                                else if (m_dir == 1 && (m_led % 2) == 1) m_dir = 0;
                                m_led = (m_dir == 0) ? (m_led * 2) % 256 : m_led / 2;
                            end
                            default: m_led = m_led;
                        endcase
                        q.push_back('{1'b0, $time, m_led});
                    end else begin
                        m_sub = (m_sub + 1) % 8;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows a step or a busy load cycle
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            while (q.size() > 0 && q[0].t + HALF < $time) begin
                ev_t ev;
                ev = q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL event_missed: got no output, expected %s led=0x%0h from edge t=%0t",
                         ev.is_load ? "load" : "step", ev.led, ev.t);
            end
            if (step_pulse === 1'b1 || pat_ready === 1'b0) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL event_unexpected: got step_pulse=%b pat_ready=%b led=0x%0h, expected no event at t=%0t",
                             step_pulse, pat_ready, led, $time);
                end else begin
                    ev_t ev;
                    ev = q.pop_front();
                    chk("event_kind", 32'(!pat_ready), 32'(ev.is_load));
                    chk("event_time", 32'($time - HALF), 32'(ev.t));
                    chk("event_led", 32'(led), 32'(ev.led));
                end
            end
        end
    end

    task automatic apply_reset(input logic [1:0] md, input logic [1:0] sp);
        @(negedge clk);
        resetn = 1'b0; pause = 1'b0; pat_valid = 1'b0; mode = md; speed = sp;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h01);
        chk("rst_ready", 32'(pat_ready), 32'd1);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        resetn = 1'b1;
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_pulse !== 1'b1 && n < limit);
        chk("step_seen", 32'(step_pulse), 32'd1);
    endtask

    task automatic load_now(input logic [7:0] p);
        pat_valid = 1'b1; pat_data = p;
        @(negedge clk);
        pat_valid = 1'b0;
        chk("load_ready_low", 32'(pat_ready), 32'd0);
        chk("load_led", 32'(led), 32'(p));
    endtask

    task automatic load(input logic [7:0] p);
        @(negedge clk);
        load_now(p);
    endtask

    initial begin
        int n, k, pulses, len, exp_led;
        int exp3 [10] = '{'h80, 'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 'h02, 'h04};
        int exp2 [3]  = '{'h80, 'h40, 'h20};

        // Rotate left at full speed, wraps after 8 steps
        apply_reset(2'd0, 2'd0);
        wait_step(200, n);
        chk("s1_first_latency", 32'(n), 32'd100);
        chk("s1_first_led", 32'(led), 32'h02);
        for (int i = 0; i < 7; i++) begin
            wait_step(200, n);
            chk("s1_period", 32'(n), 32'd100);
        end
        chk("s1_wrap_led", 32'(led), 32'h01);

        // Rotate right, one step per 4 base ticks
        apply_reset(2'd1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            wait_step(600, n);
            chk("s2_period", 32'(n), 32'd400);
            chk("s2_led", 32'(led), 32'(exp2[i]));
        end

        // Bounce from 0x40 through both end flips
        @(negedge clk); mode = 2'd2; speed = 2'd0;
        load(8'h40);
        for (int i = 0; i < 10; i++) begin
            wait_step(200, n);
            chk("s3_period", 32'(n), 32'd100);
            chk("s3_led", 32'(led), 32'(exp3[i]));
        end

        // Load arriving on the cycle a step is due
        k = 0;
        while (m_cnt != CNT_1S - 1 && k < 300) begin @(negedge clk); k++; end
        load_now(8'hA5);
        chk("s4_no_pulse", 32'(step_pulse), 32'd0);
        wait_step(200, n);
        chk("s4_restart", 32'(n), 32'd100);

        // Pause mid-count for 250 cycles
        @(negedge clk); mode = 2'd0;
        k = 0;
        while (m_cnt != 50 && k < 300) begin @(negedge clk); k++; end
        pause = 1'b1;
        exp_led = m_led;
        pulses = 0;
        repeat (250) begin @(negedge clk); if (step_pulse) pulses++; end
        chk("s5_pulses", 32'(pulses), 32'd0);
        chk("s5_frozen", 32'(led), 32'(exp_led));
        pause = 1'b0;
        wait_step(200, n);
        chk("s5_resume", 32'(n), 32'd50);

        // Load while paused stays frozen
        @(negedge clk); pause = 1'b1;
        load(8'h3C);
        pulses = 0;
        repeat (300) begin @(negedge clk); if (step_pulse) pulses++; end
        chk("s5b_pulses", 32'(pulses), 32'd0);
        chk("s5b_led", 32'(led), 32'h3C);
        pause = 1'b0;
        wait_step(200, n);
        chk("s5b_resume", 32'(n), 32'd100);

        // All-zero pattern never moves, even in bounce
        @(negedge clk); mode = 2'd2;
        load(8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_step(200, n);
            chk("zero_led", 32'(led), 32'h00);
        end

        // Asynchronous reset while the load FSM is busy
        load(8'h5A);
        #2 resetn = 1'b0;
        #1;
        chk("s6_led", 32'(led), 32'h01);
        chk("s6_ready", 32'(pat_ready), 32'd1);
        chk("s6_pulse", 32'(step_pulse), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Random traffic against the model
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            mode  = 2'($urandom_range(0, 3));
            speed = 2'($urandom_range(0, 3));
            pause = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                pat_valid = 1'b1;
                pat_data  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            len = int'($urandom_range(400, 1500));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                pat_valid = ($urandom_range(0, 99) == 0);
                pat_data  = 8'($urandom);
                if ($urandom_range(0, 79) == 0)  pause = ~pause;
                if ($urandom_range(0, 299) == 0) speed = 2'($urandom);
                if ($urandom_range(0, 399) == 0) mode  = 2'($urandom);
            end
        end

        @(negedge clk); pat_valid = 1'b0; pause = 1'b0;
        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_scroller_ctrl.md
Name: led_scroller_ctrl

Overview:
Parametrised LED scroller, successor to the fixed single-pattern scroller. It drives an LED_W-bit LED bank from an internal seconds-rate prescaler. It supports four motion modes, run-time speed selection, pause, and a valid/ready pattern-load port. It sits at board top, between switch/button inputs (or a CPU-side config register) and the LED pins.

Parameters:
LED_W, 16, number of LEDs; legal range 2..32.
CNT_W, 27, prescaler counter width.
CNT_1S, 27'd100_000_000, clk cycles per base tick; simulation uses 100.
INIT_PAT, 16'h0001, led value after reset; width LED_W.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
mode  in  2  0=rotate left, 1=rotate right, 2=bounce, 3=hold
speed  in  2  one step every 2^speed base ticks (1,2,4,8)
pause  in  1  1 freezes prescaler, divider and led
pat_valid  in  1  pattern offer
pat_data  in  LED_W  pattern to load
pat_ready  out  1  pattern port can accept
led  out  LED_W  LED drive, 1=on
step_pulse  out  1  one-cycle strobe coinciding with each led motion update

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on resetn. All state is cleared asynchronously on resetn low and is synchronous to clk otherwise.
- Reset values: led=INIT_PAT, pat_ready=1, step_pulse=0, prescaler cnt=0, divider sub=0, dir=LEFT, load FSM=READY.
- Prescaler: cnt counts 0..CNT_1S-1, then wraps to 0. tick=1 when cnt==CNT_1S-1 and pause==0. Holds its value while pause=1.
- Divider: sub (3 bits) increments on tick. step = tick && (sub == (1<<speed)-1). sub clears to 0 on step.
  - If speed is lowered so that sub already exceeds the new limit, sub wraps naturally at 7. No step is skipped twice.
- On step, led is updated in the next cycle and step_pulse=1 in that same cycle.
  - Mode 0: led <= {led[LED_W-2:0], led[LED_W-1]}.
  - Mode 1: led <= {led[0], led[LED_W-1:1]}.
  - Mode 2 (bounce): if dir==LEFT and led[LED_W-1]==1, set dir<=RIGHT and shift right. If dir==RIGHT and led[0]==1, set dir<=LEFT and shift left. Otherwise shift in dir with 0 fill.
  - Mode 3: led unchanged; step_pulse still fires.
- Mode changes take effect at the next step. dir is retained across mode changes and only used in mode 2.
- Load FSM, two states READY/BUSY:
  - READY: pat_ready=1. When pat_valid=1, go to BUSY; next cycle led<=pat_data, cnt<=0, sub<=0, dir<=LEFT.
  - BUSY: pat_ready=0 for exactly one cycle, then return to READY.
  - pat_valid while BUSY is ignored; the source must hold it.
- A load accepted in the same cycle as a step wins. No shift occurs and step_pulse=0.
- Loads are accepted while pause=1. led takes the new pattern and stays frozen.
- All-zero pattern: legal. led stays 0 in every mode and bounce never flips.
- resetn asserted mid-operation (including BUSY): immediate return to reset values.

Decomposition:
- Package led_scroller_pkg: mode encodings (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_HOLD), dir encodings, load FSM state encodings.
- Sub-module tick_prescaler: parameters CNT_W and CNT_1S; ports clk, resetn, en (=~pause), clr, tick. Its clr input is driven by pattern acceptance.

Test Plan:
All scenarios use LED_W=8 and CNT_1S=100.
1. Reset release, mode=0, speed=0 -> led=0x01. First step_pulse 100 cycles after release, led=0x02. After 8 steps led=0x01.
2. mode=1, speed=2 from reset -> step every 400 cycles. led sequence 0x80, 0x40, 0x20.
3. mode=2, load 0x40 -> steps give 0x80, 0x40, 0x20, ..., 0x01, 0x02. dir flips at 0x80 and at 0x01.
4. pat_valid held with 0xA5 in the same cycle a step is due -> pat_ready low one cycle, led=0xA5, no step_pulse. Next step occurs 100 cycles after acceptance.
5. pause=1 for 250 cycles mid-count at cnt=50 -> no led change and no step_pulse. After release the step comes 50 cycles later.
6. resetn pulsed low while the FSM is BUSY -> led=0x01, pat_ready=1 immediately, without waiting for a clk edge.
